// File: rtl/mstr_cycle_ctrl.sv
// Registered one-hot state stage for the bus arbiter: latches next-state, decodes
// active-low master grants and tracks beats/watchdog to tell the arbiter when to re-grant.
module mstr_cycle_ctrl #(
  parameter int unsigned CYCLEA    = 1,
  parameter int unsigned CYCLEC    = 2,
  parameter int unsigned MSTRA     = 3,
  parameter int unsigned MSTRB     = 4,
  parameter int unsigned MSTRC     = 5,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] next,
  input  logic       xfer_ack,
  output logic [5:0] state,
  output logic       done,
  output logic       nGNTA,
  output logic       nGNTB,
  output logic       nGNTC,
  output logic [3:0] beat_cnt,
  output logic       onehot_err,
  output logic       timeout_err
);

  localparam logic [5:0] IdleVec     = 6'(1 << CYCLEC);
  // Every bit that is not turnaround, idle or the unused bit 0 is a master-owned state.
  localparam logic [5:0] NonMstrMask = 6'(1 << CYCLEC) | 6'(1 << CYCLEA) | 6'd1;
  localparam logic [3:0] LastBeat    = 4'(BURST_LEN - 1);
  localparam logic [3:0] TimeoutVal  = 4'(TIMEOUT);

  logic [5:0] state_q, state_d;
  logic       done_q, done_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] wdog_q, wdog_d;
  logic       onehot_err_q, onehot_err_d;
  logic       timeout_err_q, timeout_err_d;

  logic       legal;
  logic       own_q;
  logic       own_d;
  logic [3:0] wdog_inc;

  always_comb begin
    legal         = $onehot(next);
    state_d       = legal ? next : IdleVec;
    onehot_err_d  = ~legal;
    own_q         = |(state_q & ~NonMstrMask);
    own_d         = |(state_d & ~NonMstrMask);
    wdog_inc      = wdog_q + 4'd1;
    done_d        = done_q;
    beat_cnt_d    = beat_cnt_q;
    wdog_d        = wdog_q;
    timeout_err_d = 1'b0;

    if (own_d && (state_d != state_q)) begin
      // New owner: start a fresh grant.
      beat_cnt_d = 4'd0;
      wdog_d     = 4'd0;
      done_d     = 1'b0;
    end else if (own_q && !done_q) begin
      if (xfer_ack) begin
        // An ack always wins over a coincident watchdog expiry.
        beat_cnt_d = beat_cnt_q + 4'd1;
        wdog_d     = 4'd0;
        if (beat_cnt_q == LastBeat) begin
          done_d = 1'b1;
        end
      end else begin
        wdog_d = wdog_inc;
        if (wdog_inc == TimeoutVal) begin
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IdleVec;
      done_q        <= 1'b1;
      beat_cnt_q    <= 4'd0;
      wdog_q        <= 4'd0;
      onehot_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      beat_cnt_q    <= beat_cnt_d;
      wdog_q        <= wdog_d;
      onehot_err_q  <= onehot_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign beat_cnt    = beat_cnt_q;
  assign onehot_err  = onehot_err_q;
  assign timeout_err = timeout_err_q;
  assign nGNTA       = ~state_q[MSTRA];
  assign nGNTB       = ~state_q[MSTRB];
  assign nGNTC       = ~state_q[MSTRC];

endmodule

// File: tb/tb_mstr_cycle_ctrl.sv
// Directed bench for mstr_cycle_ctrl with hand-computed expectations per scenario.
module tb_mstr_cycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] next;
  logic       xfer_ack;
  logic [5:0] state;
  logic       done;
  logic       nGNTA;
  logic       nGNTB;
  logic       nGNTC;
  logic [3:0] beat_cnt;
  logic       onehot_err;
  logic       timeout_err;

  int n_checks;
  int n_pass;

  localparam logic [5:0] Idle  = 6'b000100;
  localparam logic [5:0] TurnA = 6'b000010;
  localparam logic [5:0] MA    = 6'b001000;
  localparam logic [5:0] MB    = 6'b010000;
  localparam logic [5:0] MC    = 6'b100000;

  mstr_cycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .next       (next),
    .xfer_ack   (xfer_ack),
    .state      (state),
    .done       (done),
    .nGNTA      (nGNTA),
    .nGNTB      (nGNTB),
    .nGNTC      (nGNTC),
    .beat_cnt   (beat_cnt),
    .onehot_err (onehot_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; next = Idle; xfer_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (state !== Idle) $display("FAIL reset_state[%0d] got %b want %b", i, state, Idle);
      else n_pass++;
      n_checks++;
      if (done !== 1'b1) $display("FAIL reset_done[%0d] got %b want 1", i, done);
      else n_pass++;
      n_checks++;
      if ({nGNTA, nGNTB, nGNTC} !== 3'b111)
        $display("FAIL reset_gnt[%0d] got %b want 111", i, {nGNTA, nGNTB, nGNTC});
      else n_pass++;
      n_checks++;
      if ({onehot_err, timeout_err} !== 2'b00)
        $display("FAIL reset_err[%0d] got %b want 00", i, {onehot_err, timeout_err});
      else n_pass++;
    end
    n_checks++;
    if (beat_cnt !== 4'd0) $display("FAIL reset_beat got %0d want 0", beat_cnt);
    else n_pass++;
  endtask

  task automatic test_beats();
    next = MA; xfer_ack = 1'b0;
    tick();
    n_checks++;
    if ({nGNTA, nGNTB, nGNTC} !== 3'b011 || state !== MA)
      $display("FAIL beats_entry got gnt=%b state=%b want 011/%b", {nGNTA, nGNTB, nGNTC}, state, MA);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0 || beat_cnt !== 4'd0)
      $display("FAIL beats_entry_cnt got done=%b beat=%0d want 0/0", done, beat_cnt);
    else n_pass++;
    xfer_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (beat_cnt !== 4'(i)) $display("FAIL beats_cnt[%0d] got %0d want %0d", i, beat_cnt, i);
      else n_pass++;
      n_checks++;
      if (done !== (i == 4)) $display("FAIL beats_done[%0d] got %b want %b", i, done, (i == 4));
      else n_pass++;
      n_checks++;
      if (timeout_err !== 1'b0) $display("FAIL beats_tmo[%0d] got %b want 0", i, timeout_err);
      else n_pass++;
    end
    // Extra ack after completion must not move the saturated count.
    tick();
    n_checks++;
    if (beat_cnt !== 4'd4) $display("FAIL beats_sat got %0d want 4", beat_cnt);
    else n_pass++;
    xfer_ack = 1'b0; next = TurnA;
    tick();
    n_checks++;
    if (nGNTA !== 1'b1 || done !== 1'b1 || beat_cnt !== 4'd4)
      $display("FAIL beats_leave got gnt=%b done=%b beat=%0d want 1/1/4", nGNTA, done, beat_cnt);
    else n_pass++;
    next = Idle;
    tick();
  endtask

  task automatic test_timeout();
    next = MB; xfer_ack = 1'b0;
    tick();
    n_checks++;
    if (nGNTB !== 1'b0 || done !== 1'b0)
      $display("FAIL tmo_entry got gnt=%b done=%b want 0/0", nGNTB, done);
    else n_pass++;
    for (int k = 2; k <= 16; k++) begin
      tick();
      n_checks++;
      if (timeout_err !== (k == 16))
        $display("FAIL tmo_pulse[%0d] got %b want %b", k, timeout_err, (k == 16));
      else n_pass++;
      n_checks++;
      if (done !== (k == 16)) $display("FAIL tmo_done[%0d] got %b want %b", k, done, (k == 16));
      else n_pass++;
    end
    tick();
    n_checks++;
    if (timeout_err !== 1'b0 || done !== 1'b1 || beat_cnt !== 4'd0)
      $display("FAIL tmo_after got tmo=%b done=%b beat=%0d want 0/1/0", timeout_err, done, beat_cnt);
    else n_pass++;
  endtask

  task automatic test_onehot();
    logic [5:0] bad [2];
    bad[0] = 6'b011000;
    bad[1] = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      next = MB;
      tick();
      next = bad[i];
      tick();
      n_checks++;
      if (state !== Idle || onehot_err !== 1'b1)
        $display("FAIL onehot_bad[%0d] got state=%b err=%b want %b/1", i, state, onehot_err, Idle);
      else n_pass++;
      n_checks++;
      if ({nGNTA, nGNTB, nGNTC} !== 3'b111)
        $display("FAIL onehot_gnt[%0d] got %b want 111", i, {nGNTA, nGNTB, nGNTC});
      else n_pass++;
      next = Idle;
      tick();
      n_checks++;
      if (onehot_err !== 1'b0) $display("FAIL onehot_clear[%0d] got %b want 0", i, onehot_err);
      else n_pass++;
    end
    next = 6'b000001;
    tick();
    n_checks++;
    if (state !== 6'b000001 || onehot_err !== 1'b0 || {nGNTA, nGNTB, nGNTC} !== 3'b111)
      $display("FAIL onehot_bit0 got state=%b err=%b gnt=%b want 000001/0/111",
               state, onehot_err, {nGNTA, nGNTB, nGNTC});
    else n_pass++;
    next = Idle;
    tick();
  endtask

  task automatic test_reset_midburst();
    next = MC; xfer_ack = 1'b0;
    tick();
    xfer_ack = 1'b1;
    tick(); tick();
    n_checks++;
    if (beat_cnt !== 4'd2 || nGNTC !== 1'b0)
      $display("FAIL mid_pre got beat=%0d gnt=%b want 2/0", beat_cnt, nGNTC);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0; xfer_ack = 1'b0; next = Idle;
    n_checks++;
    if (state !== Idle || done !== 1'b1 || beat_cnt !== 4'd0 || nGNTC !== 1'b1)
      $display("FAIL mid_reset got state=%b done=%b beat=%0d gnt=%b want %b/1/0/1",
               state, done, beat_cnt, nGNTC, Idle);
    else n_pass++;
    tick();
  endtask

  task automatic test_simultaneous();
    next = MA; xfer_ack = 1'b0;
    tick();
    xfer_ack = 1'b1;
    repeat (3) tick();
    xfer_ack = 1'b0;
    repeat (14) tick();
    n_checks++;
    if (done !== 1'b0 || beat_cnt !== 4'd3)
      $display("FAIL simul_pre got done=%b beat=%0d want 0/3", done, beat_cnt);
    else n_pass++;
    xfer_ack = 1'b1;
    tick();
    xfer_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || timeout_err !== 1'b0 || beat_cnt !== 4'd4)
      $display("FAIL simul_final got done=%b tmo=%b beat=%0d want 1/0/4", done, timeout_err, beat_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Still in MSTRA with done=1; hand directly to MSTRB.
    next = MB; xfer_ack = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || beat_cnt !== 4'd0 || {nGNTA, nGNTB} !== 2'b10)
      $display("FAIL b2b got done=%b beat=%0d gnt=%b want 0/0/10", done, beat_cnt, {nGNTA, nGNTB});
    else n_pass++;
    xfer_ack = 1'b1;
    tick();
    n_checks++;
    if (beat_cnt !== 4'd1) $display("FAIL b2b_beat got %0d want 1", beat_cnt);
    else n_pass++;
    xfer_ack = 1'b0; next = Idle;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    next     = Idle;
    xfer_ack = 1'b0;
    test_reset();
    test_beats();
    test_timeout();
    test_onehot();
    test_reset_midburst();
    test_simultaneous();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
